soc_system_endstops: RTL and testbench
======================================

SOC_SYSTEM_ENDSTOPS -- requirements
Module: soc_system_endstops

Interface
REQ-001 SHALL have parameter WIDTH, default 6, number of endstop inputs (X/Y/Z min/max).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000, consecutive stable samples required before accepting a change; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port address, input, 2, Avalon-MM slave word address.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, read data with zero read latency.
REQ-010 SHALL have port in_port, input, WIDTH, asynchronous endstop switch levels.
REQ-011 SHALL have port irq, output, 1, level interrupt to the HPS.

Function
REQ-012 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep, per bit, a stable value and a counter sized for DEBOUNCE_CYCLES.
REQ-014 SHALL clear a bit's counter in any cycle where the synchronized value equals its stable value.
REQ-015 SHALL increment a bit's counter in each cycle where the synchronized value differs from its stable value.
REQ-016 SHALL, when a differing sample arrives with the counter at DEBOUNCE_CYCLES-1, load the stable value from the synchronized value and clear the counter in the same cycle.
REQ-017 SHALL restart qualification from zero on any glitch shorter than DEBOUNCE_CYCLES samples and leave the stable value unchanged.
REQ-018 SHALL make a held in_port change visible in the data register exactly 2+DEBOUNCE_CYCLES clocks after it is first sampled.
REQ-019 SHALL provide a register map: address 0 = data (stable values, read-only); 1 = reserved (reads 0); 2 = irqmask (RW, WIDTH bits); 3 = edgecapture (read, write-1-to-clear).
REQ-020 SHALL drive readdata combinationally from address, zero-extending WIDTH-bit fields to 32 bits; reads have no side effects.
REQ-021 SHALL accept a write when chipselect=1 and write_n=0; irqmask loads writedata[WIDTH-1:0]; writes to addresses 0 and 1 are ignored.
REQ-022 SHALL set edgecapture[i] on the cycle stable[i] transitions 0->1, regardless of irqmask.
REQ-023 SHALL clear each edgecapture bit written with 1 at address 3 and leave bits written with 0 unchanged.
REQ-024 SHALL, when a clear and a new edge hit the same bit in one cycle, let the set win.
REQ-025 SHALL drive irq = OR of (edgecapture AND irqmask), decoded combinationally from registers.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, clear synchronizers, stable values, counters, irqmask and edgecapture; irq=0 and readdata for address 0 = 0 on the next cycle.
REQ-027 SHALL abort any debounce in progress on reset; an input already high at reset release SHALL be reported as a rising edge after 2+DEBOUNCE_CYCLES clocks.

Configuration
REQ-028 SHALL, with macro ENDSTOPS_DEBOUNCE_EN defined, implement the debounce filter of REQ-013..REQ-018.
REQ-029 SHALL, without ENDSTOPS_DEBOUNCE_EN, load stable values directly from the synchronizer output every cycle (latency 3 clocks to visibility), omit the counters, and ignore DEBOUNCE_CYCLES; all other behaviour is unchanged.

Verification (DEBOUNCE_CYCLES=4, WIDTH=6, macro defined unless stated)
REQ-030 SHALL cover: in_port[0] 0->1 held -> data reads 0x01 exactly 6 clocks after first sample; edgecapture=0x01.
REQ-031 SHALL cover: 3-cycle pulse on in_port[2] -> data, edgecapture stay 0x00, irq stays 0.
REQ-032 SHALL cover: irqmask=0x04, qualified edge on bit 2 -> irq=1; write 0x04 to address 3 -> irq=0 next cycle.
REQ-033 SHALL cover: clear write to address 3 coinciding with the rising-edge cycle on the same bit -> bit remains 1.
REQ-034 SHALL cover: reset asserted mid-debounce with in_port=0x3F -> all registers 0; after release, data=0x3F and edgecapture=0x3F after 6 clocks.
REQ-035 SHALL cover: macro undefined, in_port[5] 0->1 -> data reads 0x20 after 3 clocks, even for a 1-cycle pulse.

Source files
------------

// File: rtl/soc_system_endstops.sv
// Endstop input block: synchronizes and debounces switch levels, captures rising edges, raises a level IRQ.
// Define ENDSTOPS_DEBOUNCE_EN to enable the per-bit debounce filter; otherwise stable values follow the synchronizer.
module soc_system_endstops #(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_RSVD  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;

  logic [WIDTH-1:0] w_stable_next;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  assign w_wr = chipselect && !write_n;

`ifdef ENDSTOPS_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_load;

  // A bit flips only after DEBOUNCE_CYCLES consecutive differing samples.
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    assign w_diff[i] = r_sync2[i] != r_stable[i];
    assign w_load[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt[i] <= '0;
      end else if (!w_diff[i] || w_load[i]) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign w_stable_next = r_stable ^ w_load;
`else
  logic [31:0] w_unused_dbc;
  assign w_unused_dbc  = 32'(DEBOUNCE_CYCLES);
  assign w_stable_next = r_sync2;
`endif

  // Edge is flagged in the same cycle the stable value rises.
  assign w_rise = w_stable_next & ~r_stable;
  assign w_clr  = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_stable  <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_sync1   <= in_port;
      r_sync2   <= r_sync1;
      r_stable  <= w_stable_next;
      r_edgecap <= (r_edgecap & ~w_clr) | w_rise;
      if (w_wr && address == ADDR_MASK) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(r_stable);
      ADDR_RSVD: readdata = '0;
      ADDR_MASK: readdata = 32'(r_irqmask);
      ADDR_EDGE: readdata = 32'(r_edgecap);
      default:   readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

  if (WIDTH < 32) begin : g_wd_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_soc_system_endstops.sv
// Directed bench for soc_system_endstops: stimulus queues expected readdata/irq, a monitor compares on each read strobe.
module tb_soc_system_endstops;

  localparam int unsigned W = 6;
  localparam int unsigned D = 4;
`ifdef ENDSTOPS_DEBOUNCE_EN
  localparam int unsigned LAT = 2 + D;
`else
  localparam int unsigned LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic          irq;

  soc_system_endstops #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  event rd_ev;

  // Monitor: pops one expectation per read strobe and compares readdata and irq.
  always @(rd_ev) begin
    exp_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL monitor: read strobe with no expectation queued");
    end else begin
      e = q.pop_front();
      n_vec++;
      if (readdata !== e.data) begin
        n_bad++;
        $display("FAIL %s readdata: got 0x%08h expected 0x%08h", e.name, readdata, e.data);
      end
      n_vec++;
      if (irq !== e.irq) begin
        n_bad++;
        $display("FAIL %s irq: got %b expected %b", e.name, irq, e.irq);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] a, input logic [31:0] d, input logic i);
    exp_t e;
    e.name = name;
    e.data = d;
    e.irq  = i;
    address = a;
    q.push_back(e);
    #1;
    ->rd_ev;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    tick(2);
    reset = 1'b0;
    chk("rst_data", 2'd0, 32'h0, 1'b0);
    chk("rst_rsvd", 2'd1, 32'h0, 1'b0);
    chk("rst_mask", 2'd2, 32'h0, 1'b0);
    chk("rst_edge", 2'd3, 32'h0, 1'b0);

    // Held rise on bit 0: exact latency check.
    in_port = 6'h01;
    tick(LAT - 1);
    chk("b0_early", 2'd0, 32'h00, 1'b0);
    tick(1);
    chk("b0_data", 2'd0, 32'h01, 1'b0);
    chk("b0_edge", 2'd3, 32'h01, 1'b0);
    wr(2'd3, 32'h01);
    chk("b0_clr", 2'd3, 32'h00, 1'b0);

    // Falling edge updates data but captures nothing.
    in_port = 6'h00;
    tick(LAT);
    chk("b0_fall_data", 2'd0, 32'h00, 1'b0);
    chk("b0_fall_edge", 2'd3, 32'h00, 1'b0);

    wr(2'd2, 32'h04);
    chk("mask_rd", 2'd2, 32'h04, 1'b0);

`ifdef ENDSTOPS_DEBOUNCE_EN
    // 3-cycle glitch on bit 2 must be rejected.
    in_port = 6'h04;
    tick(3);
    in_port = 6'h00;
    tick(LAT + 2);
    chk("glitch_data", 2'd0, 32'h00, 1'b0);
    chk("glitch_edge", 2'd3, 32'h00, 1'b0);
`else
    // Without filtering a 1-cycle pulse on bit 5 passes straight through.
    in_port = 6'h20;
    tick(1);
    in_port = 6'h00;
    tick(2);
    chk("pulse_data", 2'd0, 32'h20, 1'b0);
    chk("pulse_edge", 2'd3, 32'h20, 1'b0);
    tick(1);
    chk("pulse_gone", 2'd0, 32'h00, 1'b0);
    chk("pulse_held", 2'd3, 32'h20, 1'b0);
    wr(2'd3, 32'h20);
    chk("pulse_clr", 2'd3, 32'h00, 1'b0);
`endif

    // Qualified edge on masked bit 2 raises irq; clear drops it.
    in_port = 6'h04;
    tick(LAT);
    chk("b2_data", 2'd0, 32'h04, 1'b1);
    chk("b2_edge", 2'd3, 32'h04, 1'b1);
    wr(2'd3, 32'h00);
    chk("clr_zero", 2'd3, 32'h04, 1'b1);
    wr(2'd0, 32'h3F);
    chk("data_ro", 2'd0, 32'h04, 1'b1);
    wr(2'd1, 32'hFFFF_FFFF);
    chk("rsvd_ro", 2'd1, 32'h00, 1'b1);
    wr(2'd3, 32'h04);
    chk("b2_clr", 2'd3, 32'h00, 1'b0);

    // Clear on bit 1 coincides with its rising edge: set wins.
    in_port = 6'h06;
    tick(LAT - 1);
    chk("b1_pre", 2'd3, 32'h00, 1'b0);
    wr(2'd3, 32'h02);
    chk("b1_setwins", 2'd3, 32'h02, 1'b0);
    chk("b1_data", 2'd0, 32'h06, 1'b0);

    // Reset mid-debounce, then all-high input reported as edges.
    in_port = 6'h3F;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_data", 2'd0, 32'h00, 1'b0);
    chk("mid_rst_edge", 2'd3, 32'h00, 1'b0);
    chk("mid_rst_mask", 2'd2, 32'h00, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(LAT - 1);
    chk("post_rst_early", 2'd0, 32'h00, 1'b0);
    tick(1);
    chk("post_rst_data", 2'd0, 32'h3F, 1'b0);
    chk("post_rst_edge", 2'd3, 32'h3F, 1'b0);

    // Mask readback zero-extends; irq follows mask.
    wr(2'd2, 32'hFFFF_FFC1);
    chk("mask_trunc", 2'd2, 32'h01, 1'b1);
    wr(2'd2, 32'h00);
    chk("mask_off", 2'd3, 32'h3F, 1'b0);

    tick(2);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
